dp_debug_ctrl: RTL and testbench
================================

// Module: dp_debug_ctrl
// PURPOSE
//  Run/step/breakpoint controller and trace capture for the single-cycle FullDatapath.
//  Sequences the core reset, gates core progress via a clock enable (core_ce), and
//  records {PC, instruction} of each executed cycle in a circular trace buffer.
//  Sits between board/bench controls and FullDatapath; trace feeds the SSD/debug readout.
// PARAMETERS
//  XLEN        32  width of PC / bp_addr / trace_pc
//  TRACE_DEPTH 16  trace entries; power of 2, >= 2
//  RST_HOLD    4   cycles core_reset is held after reset release; >= 1
//  CYC_W       32  width of executed-cycle counter
// PORTS
//  clk          in   1                  system clock, all logic on rising edge
//  reset        in   1                  synchronous, active-low (0 = reset)
//  mode         in   2                  00 HALT, 01 RUN, 10 STEP, 11 RUN_BP
//  step_req     in   1                  level; rising edge requests one step
//  bp_addr      in   XLEN               breakpoint PC, used in RUN_BP only
//  pc_in        in   XLEN               current PC from datapath
//  instr_in     in   32                 current instruction from datapath
//  trace_rd_idx in   $clog2(TRACE_DEPTH) 0 = newest entry
//  core_reset   out  1                  active-high reset to FullDatapath
//  core_ce      out  1                  1 = datapath commits this cycle
//  halted       out  1                  1 in HALT and BREAK states
//  bp_hit       out  1                  1 while in BREAK
//  cycle_cnt    out  CYC_W              count of cycles with core_ce=1, wraps
//  trace_count  out  $clog2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH
//  trace_pc     out  XLEN               registered trace read, PC field
//  trace_instr  out  32                 registered trace read, instruction field
// BEHAVIOUR
//  Reset (reset=0 at edge): state<=RESET, hold_cnt/cycle_cnt/trace_count/wr_ptr<=0,
//   trace_pc/trace_instr<=0, step edge reg<=0; outputs: core_reset=1, core_ce=0,
//   halted=0, bp_hit=0. Applies from any state, including mid-step/mid-run.
//  States: RESET, HALT, RUN, STEP, BREAK.
//  RESET: core_reset=1, core_ce=0; hold_cnt++; after RST_HOLD cycles with reset=1 -> HALT.
//  HALT: core_ce=0. mode RUN or RUN_BP -> RUN; mode STEP & step edge -> STEP.
//  RUN: core_ce=1 except Mealy case mode=RUN_BP & pc_in==bp_addr: core_ce=0, -> BREAK
//   (breakpointed instruction not executed). mode HALT or STEP -> HALT (core_ce=0 that cycle).
//  STEP: core_ce=1 for exactly one cycle, then -> HALT regardless of step_req level.
//  BREAK: core_ce=0. step edge -> STEP (steps past bp, no re-hit); mode RUN -> RUN;
//   mode HALT/STEP(no edge) -> HALT; mode RUN_BP stays.
//  Step edge = step_req & ~step_req_q; edge in non-HALT/BREAK states is discarded.
//  Each cycle core_ce=1: mem[wr_ptr]<={pc_in,instr_in}; wr_ptr++ mod TRACE_DEPTH;
//   trace_count++ saturating at TRACE_DEPTH; cycle_cnt++ (wraps at 2^CYC_W).
//  Trace read: 1-cycle latency; entry = mem[wr_ptr-1-trace_rd_idx] using wr_ptr before the
//   write of that same cycle (read-before-write); if trace_rd_idx >= trace_count -> zeros.
//  Priority: reset > breakpoint compare > mode change > step edge.
// STRUCTURE
//  Shared header dbg_defs.vh: mode codes, state encodings (localparams).
//  Sub-module trace_buffer: circular RAM, wr_ptr, saturating count, registered read port.
//  Top: FSM, reset-hold counter, step edge detect, bp compare, cycle counter.
// TESTING
//  1 reset=0 one cycle, then 1, RST_HOLD=4 -> core_reset=1 for 5 cycles, then halted=1,
//    core_ce=0, trace_count=0, cycle_cnt=0.
//  2 mode=RUN 10 cycles, pc_in=0,4,..,36 -> core_ce=1 each, cycle_cnt=10, trace_count=10,
//    idx0 -> trace_pc=36, idx9 -> 0, idx10 -> 0 with trace_instr=0.
//  3 mode=RUN_BP, bp_addr=0x20, pc stepping by 4 from 0 -> core_ce=0 when pc_in=0x20,
//    bp_hit=1, halted=1, cycle_cnt=8, idx0 trace_pc=0x1C.
//  4 in BREAK, step_req held 1 for 5 cycles -> exactly one core_ce pulse, cycle_cnt=9,
//    idx0 trace_pc=0x20, state HALT, bp_hit=0.
//  5 TRACE_DEPTH=16, RUN 20 cycles pc=4*n -> trace_count=16, idx0=76, idx15=16; same-cycle
//    read of idx0 during a write returns previous newest.
//  6 reset=0 during RUN -> next edge core_reset=1, core_ce=0, trace_count=0, cycle_cnt=0,
//    bp_hit=0; RUN resumes only after RST_HOLD cycles and HALT.

Source files
------------

// File: rtl/dp_debug_ctrl_pkg.sv
// dp_debug_ctrl_pkg: shared mode codes and controller state encodings
// Contents:
//   mode_e  - board/bench mode selector values (HALT, RUN, STEP, RUN_BP)
//   state_e - run-control FSM states
package dp_debug_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_HALT   = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_RUN_BP = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HALT,
        ST_RUN,
        ST_STEP,
        ST_BREAK
    } state_e;

endpackage

// File: rtl/dp_debug_ctrl_trace_buffer.sv
// dp_debug_ctrl_trace_buffer: circular {PC, instruction} trace with registered read port
// Ports:
//   clk_i      - clock, rising edge
//   reset_ni   - synchronous active-low reset
//   we_i       - record {pc_i, instr_i} this cycle
//   pc_i       - PC to record
//   instr_i    - instruction to record
//   rd_idx_i   - read index, 0 = newest entry
//   count_o    - valid entries, saturates at DEPTH
//   rd_pc_o    - registered read, PC field (zero when index not valid)
//   rd_instr_o - registered read, instruction field (zero when index not valid)
module dp_debug_ctrl_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       we_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [31:0]                instr_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [XLEN-1:0]            rd_pc_o,
    output logic [31:0]                rd_instr_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [XLEN+31:0]  mem [DEPTH];
    logic [IDX_W-1:0]  wr_q;
    logic [IDX_W:0]    cnt_q;
    logic [XLEN+31:0]  rd_q;
    logic [IDX_W-1:0]  rd_addr;
    logic              rd_valid;

    // Index arithmetic wraps modulo DEPTH; wr_q here is the pre-write pointer,
    // so a read in the same cycle as a write sees the previous newest entry.
    assign rd_addr  = wr_q - 1'b1 - rd_idx_i;
    assign rd_valid = {1'b0, rd_idx_i} < cnt_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[wr_q] <= {pc_i, instr_i};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_q  <= '0;
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            if (we_i) begin
                wr_q  <= wr_q + 1'b1;
                cnt_q <= (cnt_q == (IDX_W+1)'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
            end
            rd_q <= rd_valid ? mem[rd_addr] : '0;
        end
    end

    assign count_o    = cnt_q;
    assign rd_pc_o    = rd_q[XLEN+31:32];
    assign rd_instr_o = rd_q[31:0];

endmodule

// File: rtl/dp_debug_ctrl.sv
// dp_debug_ctrl: run/step/breakpoint controller with trace capture for FullDatapath
// Ports:
//   clk_i          - clock, rising edge
//   reset_ni       - synchronous active-low reset (0 = reset)
//   mode_i         - 00 HALT, 01 RUN, 10 STEP, 11 RUN_BP
//   step_req_i     - level; rising edge requests one step
//   bp_addr_i      - breakpoint PC, used in RUN_BP only
//   pc_i           - current PC from datapath
//   instr_i        - current instruction from datapath
//   trace_rd_idx_i - trace read index, 0 = newest
//   core_reset_o   - active-high reset to datapath
//   core_ce_o      - datapath commits this cycle
//   halted_o       - in HALT or BREAK
//   bp_hit_o       - in BREAK
//   cycle_cnt_o    - count of committed cycles, wraps
//   trace_count_o  - valid trace entries, saturating
//   trace_pc_o     - registered trace read, PC field
//   trace_instr_o  - registered trace read, instruction field
module dp_debug_ctrl
    import dp_debug_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int RST_HOLD    = 4,
    parameter int CYC_W       = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [1:0]                     mode_i,
    input  logic                           step_req_i,
    input  logic [XLEN-1:0]                bp_addr_i,
    input  logic [XLEN-1:0]                pc_i,
    input  logic [31:0]                    instr_i,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx_i,
    output logic                           core_reset_o,
    output logic                           core_ce_o,
    output logic                           halted_o,
    output logic                           bp_hit_o,
    output logic [CYC_W-1:0]               cycle_cnt_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count_o,
    output logic [XLEN-1:0]                trace_pc_o,
    output logic [31:0]                    trace_instr_o
);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    state_e            state_q, state_d;
    mode_e             mode;
    logic [HOLD_W-1:0] hold_q;
    logic              step_q;
    logic [CYC_W-1:0]  cyc_q;
    logic              step_edge;
    logic              bp_match;

    assign mode      = mode_e'(mode_i);
    assign step_edge = step_req_i & ~step_q;
    assign bp_match  = (mode == MODE_RUN_BP) && (pc_i == bp_addr_i);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= ST_RESET;
            hold_q  <= '0;
            step_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= (state_q == ST_RESET) ? hold_q + 1'b1 : '0;
            step_q  <= step_req_i;
            if (core_ce_o) cyc_q <= cyc_q + 1'b1;
        end
    end

    // In BREAK a mode change to RUN/HALT outranks a step edge; a step edge with
    // mode STEP or RUN_BP executes the breakpointed instruction without re-checking it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = (hold_q == HOLD_W'(RST_HOLD - 1)) ? ST_HALT : ST_RESET;
            ST_HALT:  state_d = (mode == MODE_RUN || mode == MODE_RUN_BP) ? ST_RUN :
                                (mode == MODE_STEP && step_edge) ? ST_STEP : ST_HALT;
            ST_RUN:   state_d = bp_match ? ST_BREAK :
                                (mode == MODE_HALT || mode == MODE_STEP) ? ST_HALT : ST_RUN;
            ST_STEP:  state_d = ST_HALT;
            ST_BREAK: state_d = (mode == MODE_RUN) ? ST_RUN :
                                (mode == MODE_HALT) ? ST_HALT :
                                step_edge ? ST_STEP :
                                (mode == MODE_STEP) ? ST_HALT : ST_BREAK;
            default:  state_d = ST_RESET;
        endcase
    end

    // A low reset_ni forces the core into reset and stops commits in that same
    // cycle, so nothing is recorded on the edge that clears the trace.
    always_comb begin
        core_reset_o = (state_q == ST_RESET) || !reset_ni;
        core_ce_o    = reset_ni && ((state_q == ST_STEP) ||
                       (state_q == ST_RUN && (mode == MODE_RUN || (mode == MODE_RUN_BP && !bp_match))));
        halted_o     = (state_q == ST_HALT) || (state_q == ST_BREAK);
        bp_hit_o     = state_q == ST_BREAK;
    end

    assign cycle_cnt_o = cyc_q;

    dp_debug_ctrl_trace_buffer #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .we_i       (core_ce_o),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .rd_idx_i   (trace_rd_idx_i),
        .count_o    (trace_count_o),
        .rd_pc_o    (trace_pc_o),
        .rd_instr_o (trace_instr_o)
    );

endmodule

// File: tb/tb_dp_debug_ctrl.sv
// tb_dp_debug_ctrl: directed self-checking bench for dp_debug_ctrl
module tb_dp_debug_ctrl;
    logic        clk = 1'b0;
    logic        reset_ni;
    logic [1:0]  mode;
    logic        step_req;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  rd_idx;
    logic        core_reset;
    logic        core_ce;
    logic        halted;
    logic        bp_hit;
    logic [31:0] cycle_cnt;
    logic [4:0]  trace_count;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulses;

    always #5 clk = ~clk;

    dp_debug_ctrl #(
        .XLEN        (32),
        .TRACE_DEPTH (16),
        .RST_HOLD    (4),
        .CYC_W       (32)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .mode_i         (mode),
        .step_req_i     (step_req),
        .bp_addr_i      (bp_addr),
        .pc_i           (pc),
        .instr_i        (instr),
        .trace_rd_idx_i (rd_idx),
        .core_reset_o   (core_reset),
        .core_ce_o      (core_ce),
        .halted_o       (halted),
        .bp_hit_o       (bp_hit),
        .cycle_cnt_o    (cycle_cnt),
        .trace_count_o  (trace_count),
        .trace_pc_o     (trace_pc),
        .trace_instr_o  (trace_instr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mode = 2'b00;
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        reset_ni = 1'b0;
        mode     = 2'b00;
        step_req = 1'b0;
        bp_addr  = '0;
        pc       = '0;
        instr    = '0;
        rd_idx   = '0;

        // 1: reset sequencing
        #2;
        check("t1_core_reset_pre", core_reset, 1);
        check("t1_ce_pre", core_ce, 0);
        tick();
        reset_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t1_core_reset_hold", core_reset, 1);
            check("t1_halted_hold", halted, 0);
            tick();
        end
        check("t1_core_reset_done", core_reset, 0);
        check("t1_halted", halted, 1);
        check("t1_ce", core_ce, 0);
        check("t1_bp_hit", bp_hit, 0);
        check("t1_trace_count", trace_count, 0);
        check("t1_cycle_cnt", cycle_cnt, 0);

        // 2: RUN for 10 cycles
        mode = 2'b01;
        tick();
        for (int n = 0; n < 10; n++) begin
            pc    = 32'(4 * n);
            instr = 32'hA500_0000 + 32'(n);
            #1;
            check("t2_ce_run", core_ce, 1);
            tick();
        end
        mode = 2'b00;
        #1;
        check("t2_ce_mode_halt", core_ce, 0);
        tick();
        check("t2_halted", halted, 1);
        check("t2_cycle_cnt", cycle_cnt, 10);
        check("t2_trace_count", trace_count, 10);
        rd_idx = 4'd0;
        tick();
        check("t2_idx0_pc", trace_pc, 36);
        check("t2_idx0_instr", trace_instr, 32'hA500_0009);
        rd_idx = 4'd9;
        tick();
        check("t2_idx9_pc", trace_pc, 0);
        check("t2_idx9_instr", trace_instr, 32'hA500_0000);
        rd_idx = 4'd10;
        tick();
        check("t2_idx10_pc", trace_pc, 0);
        check("t2_idx10_instr", trace_instr, 0);

        // 3: RUN_BP hits breakpoint at 0x20
        do_reset();
        check("t3_post_reset_cnt", cycle_cnt, 0);
        bp_addr = 32'h20;
        mode    = 2'b11;
        pc      = 32'h0;
        tick();
        for (int n = 0; n < 8; n++) begin
            pc    = 32'(4 * n);
            instr = 32'hB000_0000 + 32'(n);
            #1;
            check("t3_ce_run", core_ce, 1);
            tick();
        end
        pc    = 32'h20;
        instr = 32'hB000_0008;
        #1;
        check("t3_ce_at_bp", core_ce, 0);
        tick();
        check("t3_bp_hit", bp_hit, 1);
        check("t3_halted", halted, 1);
        check("t3_ce_break", core_ce, 0);
        check("t3_cycle_cnt", cycle_cnt, 8);
        rd_idx = 4'd0;
        tick();
        check("t3_idx0_pc", trace_pc, 32'h1C);
        check("t3_still_break", bp_hit, 1);

        // 4: single step past the breakpoint with step_req held high
        mode     = 2'b10;
        step_req = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (core_ce) pulses++;
            tick();
        end
        step_req = 1'b0;
        check("t4_pulses", pulses, 1);
        check("t4_cycle_cnt", cycle_cnt, 9);
        check("t4_halted", halted, 1);
        check("t4_bp_hit", bp_hit, 0);
        tick();
        check("t4_idx0_pc", trace_pc, 32'h20);
        check("t4_idx0_instr", trace_instr, 32'hB000_0008);

        // 5: wrap the trace buffer; same-cycle read returns previous newest
        mode = 2'b01;
        tick();
        for (int n = 0; n < 20; n++) begin
            pc     = 32'(4 * n);
            instr  = 32'hC000_0000 + 32'(n);
            rd_idx = 4'd0;
            #1;
            check("t5_ce_run", core_ce, 1);
            tick();
            check("t5_rbw_idx0", trace_pc, (n == 0) ? 64'h20 : 64'(4 * (n - 1)));
        end
        mode = 2'b00;
        tick();
        check("t5_trace_count", trace_count, 16);
        check("t5_cycle_cnt", cycle_cnt, 29);
        rd_idx = 4'd0;
        tick();
        check("t5_idx0_pc", trace_pc, 76);
        rd_idx = 4'd15;
        tick();
        check("t5_idx15_pc", trace_pc, 16);
        check("t5_idx15_instr", trace_instr, 32'hC000_0004);

        // 6: reset asserted mid-RUN
        mode = 2'b01;
        tick();
        for (int n = 0; n < 3; n++) begin
            pc = 32'h100 + 32'(4 * n);
            tick();
        end
        reset_ni = 1'b0;
        #1;
        check("t6_ce_in_reset_cycle", core_ce, 0);
        tick();
        reset_ni = 1'b1;
        check("t6_core_reset", core_reset, 1);
        check("t6_ce", core_ce, 0);
        check("t6_trace_count", trace_count, 0);
        check("t6_cycle_cnt", cycle_cnt, 0);
        check("t6_bp_hit", bp_hit, 0);
        check("t6_halted", halted, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_core_reset_hold", core_reset, 1);
            check("t6_ce_hold", core_ce, 0);
        end
        tick();
        check("t6_halt_reached", halted, 1);
        check("t6_core_reset_done", core_reset, 0);
        check("t6_ce_halt", core_ce, 0);
        tick();
        check("t6_run_resumed", core_ce, 1);
        check("t6_not_halted", halted, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
